// File: rtl/uart_cmd_pkg.sv
// Shared types and default constants for the UART command receiver.
package uart_cmd_pkg;

  localparam int         DEF_CLKS_PER_BIT = 1085;
  localparam logic [7:0] DEF_SYNC_BYTE    = 8'hA5;
  localparam int         DEF_TIMEOUT_CLKS = 12500000;

  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP,
    B_WAIT_HIGH
  } byte_state_t;

  typedef enum logic [1:0] {
    P_SYNC,
    P_CMD,
    P_ARG
`ifdef UART_CMD_RX_CHECKSUM_EN
    , P_CHK
`endif
  } parser_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-FF line synchroniser followed by the byte FSM.
//
// state       | meaning
// B_IDLE      | line idle, waiting for a low level
// B_START     | timing to mid start bit to reject glitches
// B_DATA      | sampling 8 data bits, LSB first, one per bit period
// B_STOP      | sampling the stop bit at mid-bit
// B_WAIT_HIGH | stop bit was low; wait for the line to return high
module uart_byte_rx
  import uart_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       Clk,
  input  logic       i_Rst_n,
  input  logic       i_RX,
  output logic [7:0] o_Byte,
  output logic       o_Byte_Valid,
  output logic       o_Frame_Err
);

  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);

  logic        rx_meta;
  logic        rx_s;
  byte_state_t bstate;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  // Bring the asynchronous line into the clock domain; idles high.
  always_ff @(posedge Clk) begin
    if (!i_Rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_RX;
      rx_s    <= rx_meta;
    end
  end

  // Byte FSM: mid-bit sampling, stop-bit check, registered strobes.
  always_ff @(posedge Clk) begin
    if (!i_Rst_n) begin
      bstate       <= B_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      o_Byte       <= '0;
      o_Byte_Valid <= 1'b0;
      o_Frame_Err  <= 1'b0;
    end else begin
      o_Byte_Valid <= 1'b0;
      o_Frame_Err  <= 1'b0;
      case (bstate)
        B_IDLE: begin
          cnt <= '0;
          if (!rx_s) bstate <= B_START;
        end
        B_START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            bstate  <= rx_s ? B_IDLE : B_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        B_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) bstate <= B_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        B_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              o_Byte       <= shreg;
              o_Byte_Valid <= 1'b1;
              bstate       <= B_IDLE;
            end else begin
              o_Frame_Err  <= 1'b1;
              bstate       <= B_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        B_WAIT_HIGH: begin
          if (rx_s) bstate <= B_IDLE;
        end
        default: bstate <= B_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: byte receiver plus frame parser with inter-byte
// timeout. Define UART_CMD_RX_CHECKSUM_EN for 4-byte frames carrying a
// cmd^arg checksum; otherwise frames are sync, cmd, arg.
//
// state  | meaning
// P_SYNC | waiting for the sync byte
// P_CMD  | next byte is the command
// P_ARG  | next byte is the argument
// P_CHK  | next byte is the checksum (checksum builds only)
module uart_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter int         CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE,
  parameter int         TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
  input  logic       Clk,
  input  logic       i_Rst_n,
  input  logic       i_RX,
  output logic [7:0] o_Byte,
  output logic       o_Byte_Valid,
  output logic [7:0] o_Cmd,
  output logic [7:0] o_Arg,
  output logic       o_Cmd_Valid,
  output logic       o_Frame_Err,
  output logic       o_Chk_Err,
  output logic       o_Busy
);

  localparam int              TW       = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  parser_state_t pstate;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    pend_cmd;
`ifdef UART_CMD_RX_CHECKSUM_EN
  logic [7:0]    pend_arg;
`endif

  uart_byte_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte_rx (
    .Clk          (Clk),
    .i_Rst_n      (i_Rst_n),
    .i_RX         (i_RX),
    .o_Byte       (o_Byte),
    .o_Byte_Valid (o_Byte_Valid),
    .o_Frame_Err  (o_Frame_Err)
  );

  assign o_Busy = (pstate != P_SYNC);

`ifndef UART_CMD_RX_CHECKSUM_EN
  assign o_Chk_Err = 1'b0;
`endif

  // Parser FSM; a received byte takes priority over abort by timeout or framing error.
  always_ff @(posedge Clk) begin
    if (!i_Rst_n) begin
      pstate      <= P_SYNC;
      tmo_cnt     <= '0;
      pend_cmd    <= '0;
      o_Cmd       <= '0;
      o_Arg       <= '0;
      o_Cmd_Valid <= 1'b0;
`ifdef UART_CMD_RX_CHECKSUM_EN
      pend_arg    <= '0;
      o_Chk_Err   <= 1'b0;
`endif
    end else begin
      o_Cmd_Valid <= 1'b0;
`ifdef UART_CMD_RX_CHECKSUM_EN
      o_Chk_Err   <= 1'b0;
`endif
      if (o_Byte_Valid) begin
        tmo_cnt <= '0;
        case (pstate)
          P_SYNC: begin
            if (o_Byte == SYNC_BYTE) pstate <= P_CMD;
          end
          P_CMD: begin
            pend_cmd <= o_Byte;
            pstate   <= P_ARG;
          end
          P_ARG: begin
`ifdef UART_CMD_RX_CHECKSUM_EN
            pend_arg <= o_Byte;
            pstate   <= P_CHK;
`else
            o_Cmd       <= pend_cmd;
            o_Arg       <= o_Byte;
            o_Cmd_Valid <= 1'b1;
            pstate      <= P_SYNC;
`endif
          end
`ifdef UART_CMD_RX_CHECKSUM_EN
          P_CHK: begin
            if (o_Byte == (pend_cmd ^ pend_arg)) begin
              o_Cmd       <= pend_cmd;
              o_Arg       <= pend_arg;
              o_Cmd_Valid <= 1'b1;
            end else begin
              o_Chk_Err   <= 1'b1;
            end
            pstate <= P_SYNC;
          end
`endif
          default: pstate <= P_SYNC;
        endcase
      end else if (pstate == P_SYNC) begin
        tmo_cnt <= '0;
      end else if (o_Frame_Err || tmo_cnt == TMO_LAST) begin
        pstate  <= P_SYNC;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Randomised scoreboard bench for uart_cmd_rx, with short bit and timeout
// periods so the whole run stays small.
module tb_uart_cmd_rx;

  localparam int         CPB  = 16;
  localparam int         TMO  = 1000;
  localparam logic [7:0] SYNC = 8'hA5;
`ifdef UART_CMD_RX_CHECKSUM_EN
  localparam int FLEN = 4;
`else
  localparam int FLEN = 3;
`endif

  logic       Clk = 1'b0;
  logic       i_Rst_n = 1'b0;
  logic       i_RX = 1'b1;
  logic [7:0] o_Byte;
  logic       o_Byte_Valid;
  logic [7:0] o_Cmd;
  logic [7:0] o_Arg;
  logic       o_Cmd_Valid;
  logic       o_Frame_Err;
  logic       o_Chk_Err;
  logic       o_Busy;

  int n_cmp = 0;
  int n_err = 0;

  // scoreboard queues and frame-level reference model
  logic [7:0]  exp_byte_q[$];
  logic [15:0] exp_cmd_q[$];
  logic [15:0] exp_chk_q[$];
  int          exp_fe = 0;
  logic [7:0]  frame[$];
  logic [7:0]  last_cmd = 8'h00;
  logic [7:0]  last_arg = 8'h00;

  always #5 Clk = ~Clk;

  uart_cmd_rx #(
    .CLKS_PER_BIT (CPB),
    .SYNC_BYTE    (SYNC),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .Clk          (Clk),
    .i_Rst_n      (i_Rst_n),
    .i_RX         (i_RX),
    .o_Byte       (o_Byte),
    .o_Byte_Valid (o_Byte_Valid),
    .o_Cmd        (o_Cmd),
    .o_Arg        (o_Arg),
    .o_Cmd_Valid  (o_Cmd_Valid),
    .o_Frame_Err  (o_Frame_Err),
    .o_Chk_Err    (o_Chk_Err),
    .o_Busy       (o_Busy)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: strobe seen with nothing expected (t=%0t)", name, $time);
  endtask

  function automatic void commit(input logic [7:0] c, input logic [7:0] a);
    last_cmd = c;
    last_arg = a;
    exp_cmd_q.push_back({c, a});
  endfunction

  // a clean byte arrives: apply the frame rules to a list of collected bytes
  function automatic void model_rx(input logic [7:0] b);
    exp_byte_q.push_back(b);
    if (frame.size() == 0) begin
      if (b == SYNC) frame.push_back(b);
    end else begin
      frame.push_back(b);
      if (frame.size() == FLEN) begin
`ifdef UART_CMD_RX_CHECKSUM_EN
        if (frame[3] != (frame[1] ^ frame[2])) exp_chk_q.push_back({last_cmd, last_arg});
        else commit(frame[1], frame[2]);
`else
        commit(frame[1], frame[2]);
`endif
        frame.delete();
      end
    end
  endfunction

  // drive one 8N1 character; stimulus changes on falling edges only
  task automatic tx_bits(input logic [7:0] b, input logic stop_bit);
    i_RX = 1'b0;
    repeat (CPB) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      i_RX = b[i];
      repeat (CPB) @(negedge Clk);
    end
    i_RX = stop_bit;
    repeat (CPB) @(negedge Clk);
    i_RX = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    model_rx(b);
    tx_bits(b, 1'b1);
    repeat (gap) @(negedge Clk);
    if (gap >= 4) check("busy", {15'd0, o_Busy}, {15'd0, frame.size() != 0});
  endtask

  task automatic send_fe(input logic [7:0] b, input int gap);
    exp_fe++;
    frame.delete();
    tx_bits(b, 1'b0);
    repeat (gap) @(negedge Clk);
    check("busy_after_fe", {15'd0, o_Busy}, 16'd0);
  endtask

  task automatic glitch(input int len);
    i_RX = 1'b0;
    repeat (len) @(negedge Clk);
    i_RX = 1'b1;
    repeat (2 * CPB) @(negedge Clk);
    check("busy_after_glitch", {15'd0, o_Busy}, {15'd0, frame.size() != 0});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte"}, {8'h00, o_Byte}, 16'h0000);
    check({tag, "_cmd_arg"}, {o_Cmd, o_Arg}, 16'h0000);
    check({tag, "_busy"}, {15'd0, o_Busy}, 16'd0);
    check({tag, "_strobes"}, {12'd0, o_Byte_Valid, o_Cmd_Valid, o_Frame_Err, o_Chk_Err}, 16'd0);
  endtask

  // monitor: pops an expectation for every strobe the DUT raises
  initial forever begin
    @(negedge Clk);
    if (o_Byte_Valid) begin
      if (exp_byte_q.size() == 0) unexpected("byte_valid");
      else check("byte", {8'h00, o_Byte}, {8'h00, exp_byte_q.pop_front()});
    end
    if (o_Cmd_Valid) begin
      if (exp_cmd_q.size() == 0) unexpected("cmd_valid");
      else check("cmd_arg", {o_Cmd, o_Arg}, exp_cmd_q.pop_front());
    end
    if (o_Chk_Err) begin
      if (exp_chk_q.size() == 0) unexpected("chk_err");
      else check("chk_err_hold", {o_Cmd, o_Arg}, exp_chk_q.pop_front());
    end
    if (o_Frame_Err) begin
      if (exp_fe == 0) unexpected("frame_err");
      else begin
        exp_fe--;
        check("frame_err_no_byte", {15'd0, o_Byte_Valid}, 16'd0);
      end
    end
  end

  initial begin
    logic [7:0] c, a, k, partial;
    int kind, gap;

    repeat (4) @(negedge Clk);
    check_reset_outputs("reset");
    i_Rst_n = 1'b1;
    repeat (4) @(negedge Clk);

    // good frame, back to back
    send(SYNC, 0); send(8'h01, 0); send(8'h10, 0); send(8'h11, 8);
    check("good_cmd_arg", {o_Cmd, o_Arg}, 16'h0110);

    // bad checksum
    send(SYNC, 4); send(8'h02, 4); send(8'h20, 4); send(8'h00, 8);
    check("bad_chk_hold", {o_Cmd, o_Arg}, {last_cmd, last_arg});

    // framing error, then a good frame
    send_fe(8'h5A, 8);
    send(SYNC, 4); send(8'h03, 4); send(8'h30, 4); send(8'h33, 8);
    check("after_fe_cmd_arg", {o_Cmd, o_Arg}, 16'h0330);

    // glitch and noise bytes
    glitch(4);
    send(8'h00, 4); send(8'hFF, 4);
    send(SYNC, 4); send(8'h04, 4); send(8'h40, 4); send(8'h44, 8);
    check("noise_cmd_arg", {o_Cmd, o_Arg}, 16'h0440);

    // inter-byte timeout
    send(SYNC, 4); send(8'h05, 4);
    repeat (TMO + 100) @(negedge Clk);
    frame.delete();
    check("busy_after_timeout", {15'd0, o_Busy}, 16'd0);
    send(8'h06, 4); send(8'h60, 4); send(8'h66, 8);
    check("timeout_hold", {o_Cmd, o_Arg}, {last_cmd, last_arg});

    // reset during the data bits of the argument byte
    send(SYNC, 4); send(8'h09, 4);
    partial = 8'h6C;
    i_RX = 1'b0;
    repeat (CPB) @(negedge Clk);
    for (int i = 0; i < 3; i++) begin
      i_RX = partial[i];
      repeat (CPB) @(negedge Clk);
    end
    i_Rst_n = 1'b0;
    i_RX = 1'b1;
    repeat (3) @(negedge Clk);
    frame.delete();
    last_cmd = 8'h00;
    last_arg = 8'h00;
    check_reset_outputs("mid_reset");
    i_Rst_n = 1'b1;
    repeat (4) @(negedge Clk);
    send(SYNC, 4); send(8'h07, 4); send(8'h70, 4); send(8'h77, 8);
    check("post_reset_cmd_arg", {o_Cmd, o_Arg}, 16'h0770);

    // randomised traffic
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 9);
      gap  = $urandom_range(4, 100);
      c = 8'($urandom);
      a = 8'($urandom);
      k = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (c ^ a);
      if (kind <= 4) begin
        send(SYNC, gap); send(c, gap); send(a, gap); send(k, gap);
      end else if (kind <= 6) begin
        send(c, gap);
      end else if (kind == 7) begin
        glitch($urandom_range(1, 5));
      end else if (kind == 8) begin
        send_fe(c, gap);
      end else begin
        send(SYNC, 0); send(c, 0); send(a, 0); send(k, gap);
      end
    end

    // drain: let any partial frame time out, then every expectation must be consumed
    repeat (TMO + 100) @(negedge Clk);
    frame.delete();
    check("final_busy", {15'd0, o_Busy}, 16'd0);
    check("left_bytes", 16'(exp_byte_q.size()), 16'd0);
    check("left_cmds", 16'(exp_cmd_q.size()), 16'd0);
    check("left_chk", 16'(exp_chk_q.size()), 16'd0);
    check("left_fe", 16'(exp_fe), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
